// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Desc     : Shared RV32M op encodings, FSM states and constants for mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic op_signed_a(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_signed_b(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Desc     : One combinational restoring-division step (shift in a dividend bit,
//            trial-subtract the divisor, keep the difference if non-negative).
// Revision : 1.0 - initial release
// ============================================================================
module div_step
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] divisor,
  input  logic         dividend_bit,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted = {rem_in, dividend_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // The remainder stays below the divisor, so W bits always hold the difference.
  assign rem_out = q_bit ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Desc     : Iterative RV32M multiply/divide unit (shift-add multiply, restoring
//            divide, one op in flight). Define MULDIV_FAST_MUL_EN for a
//            single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RD_W-1:0]  rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RD_W-1:0]  rd_out,
  output logic             wb_en
);

  localparam logic [5:0] CNT_LAST = 6'(ITER_COUNT);
  localparam int         PW       = 2 * WIDTH;

  if (WIDTH != 32) begin : g_width_check
    $error("mul_div_unit: only WIDTH=32 is supported");
  end

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [PW-1:0]     acc_q, acc_d;     // {product} or {remainder, dividend/quotient}
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  md_op_e            op_in;
  logic              a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [PW-1:0]     prod_fix;
  logic [WIDTH-1:0]  div_sel, div_fix;
  logic [WIDTH-1:0]  step_rem;
  logic              step_q;

  assign op_in = md_op_e'(funct3);
  assign a_neg = op_signed_a(op_in) & op_a[WIDTH-1];
  assign b_neg = op_signed_b(op_in) & op_b[WIDTH-1];
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;
  assign div0  = (op_b == '0);
  assign ovf   = ((op_in == MD_DIV) || (op_in == MD_REM)) && (op_a == INT_MIN) && (op_b == '1);

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign div_sel  = ((op_q == MD_REM) || (op_q == MD_REMU)) ? acc_q[PW-1:WIDTH] : acc_q[WIDTH-1:0];
  assign div_fix  = neg_q ? -div_sel : div_sel;

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH:0]  fast_a, fast_b;
  logic [PW-1:0]   fast_prod;
  assign fast_a    = {op_signed_a(op_in) & op_a[WIDTH-1], op_a};
  assign fast_b    = {op_signed_b(op_in) & op_b[WIDTH-1], op_b};
  assign fast_prod = PW'($signed(fast_a) * $signed(fast_b));
`else
  logic [WIDTH:0]  mul_sum;
  assign mul_sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`endif

  div_step #(.W(WIDTH)) u_div_step (
    .rem_in       (acc_q[PW-1:WIDTH]),
    .divisor      (opnd_q),
    .dividend_bit (acc_q[WIDTH-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d  = op_in;
            rd_d  = rd_in;
            cnt_d = '0;
            if (funct3[2]) begin
              opnd_d = mag_b;
              acc_d  = {{WIDTH{1'b0}}, mag_a};
              neg_d  = ((op_in == MD_REM) || (op_in == MD_REMU)) ? a_neg : (a_neg ^ b_neg);
              if (div0) begin
                result_d = funct3[1] ? op_a : DIV0_QUOT;
                state_d  = ST_DONE;
              end else if (ovf) begin
                result_d = funct3[1] ? '0 : INT_MIN;
                state_d  = ST_DONE;
              end else begin
                state_d  = ST_DIV;
              end
            end else begin
              opnd_d = mag_a;
              acc_d  = {{WIDTH{1'b0}}, mag_b};
              neg_d  = a_neg ^ b_neg;
`ifdef MULDIV_FAST_MUL_EN
              result_d = (op_in == MD_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[PW-1:WIDTH];
              state_d  = ST_DONE;
`else
              state_d  = ST_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          if (cnt_q == CNT_LAST) begin
            result_d = (op_q == MD_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
            state_d  = ST_DONE;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 6'd1;
          end
        end
`endif
        ST_DIV: begin
          if (cnt_q == CNT_LAST) begin
            result_d = div_fix;
            state_d  = ST_DONE;
          end else begin
            acc_d = {step_rem, acc_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // A flush arriving in DONE must kill the writeback in that same cycle.
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE) && !flush;
  assign wb_en  = done;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Desc     : Scoreboard bench for mul_div_unit with a plain-arithmetic RV32M model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  mul_div_unit #(.WIDTH(32), .RD_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .wb_en  (wb_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    ps = '0;
    pu = {32'd0, a} * {32'd0, b};
    case (f)
      3'd0: return pu[31:0];
      3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accepting edge until the cycle in which done is high.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 32'd0) return 0;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 0;
`else
    return 33;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
        end else begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          check("wb_en", {31'd0, wb_en}, 32'd1);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, output int lat);
    wait_idle();
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = exp_lat(f, a, b);
    if (push) sb_q.push_back('{res: ref_op(f, a, b), rd: rd, cyc: cyc + lat});
  endtask

  initial begin
    int lat;
    int bad;
    int n;
    logic [2:0]  f;
    logic [31:0] a, b;

    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_wb_en", {31'd0, wb_en}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b1;

    // MUL 7 x -3 with busy held for the whole operation
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, lat);
    bad = 0;
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) @(negedge clk);
      if (!busy) bad++;
    end
    check("mul_busy_throughout", 32'(bad), 32'd0);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1, lat);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, lat);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, lat);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, lat);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, lat);
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1, lat);
    issue(3'd7, 32'd100, 32'd7, 5'd12, 1'b1, lat);
    issue(3'd4, 32'd5, 32'd0, 5'd13, 1'b1, lat);
    issue(3'd6, 32'd5, 32'd0, 5'd14, 1'b1, lat);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, lat);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1, lat);

    // flush at iteration 10 of a DIV, with a competing start in the same cycle
    issue(3'd4, 32'd1000, 32'd7, 5'd4, 1'b0, lat);
    repeat (11) @(negedge clk);
    flush  = 1'b1;
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd1;
    op_b   = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 5'd17, 1'b1, lat);

    // flush while in DONE suppresses the writeback
    issue(3'd4, 32'd5, 32'd0, 5'd2, 1'b0, lat);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_suppress", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_done_busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored
    issue(3'd5, 32'd100, 32'd7, 5'd18, 1'b1, lat);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd1;
    op_b   = 32'd1;
    rd_in  = 5'd19;
    @(negedge clk);
    start = 1'b0;

    // asynchronous reset mid-MUL
    issue(3'd0, 32'h1234, 32'h5678, 5'd9, 1'b0, lat);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_wb_en", {31'd0, wb_en}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(3'd5, 32'd9, 32'd3, 5'd3, 1'b1, lat);

    // randomized back-to-back traffic
    for (int i = 0; i < 120; i++) begin
      f = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(50)); b = 32'($urandom_range(15)); end
        3: begin a = -32'($urandom_range(50)); b = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      issue(f, a, b, 5'($urandom_range(31)), 1'b1, lat);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_done: %0d results outstanding, expected 0", sb_q.size());
    end
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two source operands read from the register file (rs1/rs2 data), plus funct3 and destination register index.
- Produces a 32-bit result and rd index for writeback into the register file.
- Stalls the front end while busy; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported, guarded by elaboration check.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 data (dividend / multiplicand).
- op_b  input  WIDTH  rs2 data (divisor / multiplier).
- rd_in  input  RD_W  destination index, captured with operands.
- flush  input  1  abort in-flight operation (branch mispredict / trap).
- busy  output  1  high from acceptance until DONE exits; drives pipeline stall.
- done  output  1  one-cycle pulse; result/rd_out valid this cycle only.
- result  output  WIDTH  final value for writeback.
- rd_out  output  RD_W  captured rd_in.
- wb_en  output  1  equals done; register-file write enable.

Behaviour:
- Reset: clk and rst fixed as one clock, asynchronous active-low reset. While rst low: state IDLE, busy=0, done=0, wb_en=0, result=0, rd_out=0, counter=0, all datapath registers 0. Reset mid-operation discards everything; no done is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE: start=1 at edge k captures operands, funct3, and rd_in; computes operand magnitudes and sign flags; counter=0.
  - Normal op -> MUL or DIV.
  - Special divide case -> DONE directly; done asserted in the cycle after edge k.
- MUL: shift-add over 32 iterations on 64-bit product of magnitudes; counter increments per edge; after iteration 31 -> DONE.
- DIV: restoring division, 32 iterations, one quotient bit per edge; after iteration 31 -> DONE.
- Normal latency: done is high in the cycle after edge k+33 (32 iterations + 1 sign-fix/select edge).
- DONE: result and rd_out valid, done=wb_en=1 for exactly one cycle; next edge -> IDLE, busy=0.
- A new start may be accepted on the first IDLE cycle, giving back-to-back operation.
- busy=1 in MUL, DIV and DONE. start while busy is ignored; no queueing.
- Signedness:
  - MUL: low 32 bits, independent of sign.
  - MULH: high 32 bits, signed x signed.
  - MULHSU: high 32 bits, signed x unsigned.
  - MULHU: high 32 bits, unsigned x unsigned.
  - DIV/REM: signed; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Divide by zero (op_b=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
- Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Both special cases take the fast path (1-cycle latency); no exceptions raised.
- flush=1 in any state -> IDLE next edge; done suppressed, busy=0 the following cycle.
  - flush has priority over start in the same cycle.
  - flush in DONE suppresses done/wb_en combinationally.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: multiply ops use a single-cycle combinational 33x33 signed product. IDLE -> DONE directly, so done arrives in the cycle after edge k; the MUL state is not built. Divide behaviour is unchanged.
- Not defined: iterative multiply as described above (33-cycle latency).

Decomposition:
- Package muldiv_pkg holds:
  - funct3 encodings as a typedef'd enum (MD_MUL..MD_REMU).
  - The state enum.
  - Constants: ITER_COUNT=32, DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One natural sub-module: div_step, a combinational restoring-division step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit. Instantiated once.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD) -> done one cycle after edge k+33, result=0xFFFFFFEB, rd_out=rd_in, busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; each with done one cycle after acceptance.
- flush at iteration 10 of a DIV -> no done, busy low two cycles later; an immediate new MUL 3x4 -> 12. A start asserted while busy is ignored (no second done).
- Async rst low mid-MUL -> all outputs 0 immediately; after release, DIVU 9/3 -> 3 with nominal latency.
